pipelined_adder_param: RTL and testbench
========================================

Name: pipelined_adder_param

Overview:
Parametrised, pipelined successor to the 4-bit ripple-carry adder. It splits a WIDTH-bit add/subtract into STAGES segments of SEG bits, one segment per pipeline stage. The carry is registered between segments and the operands are skewed, so the block accepts one operation per clock. It uses valid/ready handshakes on both sides and sits between operand producers and result consumers in datapath blocks that need a wide adder at full clock rate.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG (local, not overridable).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set is valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0; ignored when sub=1.
- sub  input  1  0: a+b+carry_in; 1: a-b (a + ~b + 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB; when sub=1, 1 means no borrow (a>=b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset: when rst=1 at a rising edge, all stage valid bits clear. After that edge, out_valid=0, sum=0, carry_out=0 and overflow=0. in_ready=1 while rst is asserted and after it.
- Reset mid-operation: all in-flight operations are discarded and no stale result is ever presented. rst has priority over every handshake event in the same cycle.
- Global enable: en = !out_valid || out_ready. All stages advance together when en=1 and hold when en=0. in_ready = en, which is combinational from out_ready and out_valid.
- Accept: an operation is accepted on an edge where in_valid && in_ready. On that edge:
  - stage 0 captures a, b_eff = sub ? ~b : b, and c0 = sub ? 1 : carry_in;
  - stage 0 computes segment 0 (bits SEG-1:0) and registers the segment sum and the segment carry;
  - the remaining operand segments are registered for later stages.
- Stage k (1..STAGES-1): adds segment k of a and b_eff plus the registered carry from stage k-1. It forwards the completed lower sum bits, the new carry and the remaining operand segments.
- Last stage: also records the carry into the MSB, which is used for overflow.
- Latency: a result accepted at edge n has out_valid=1 in the cycle after edge n+STAGES-1, i.e. STAGES cycles from acceptance with no stalls.
- Throughput: 1 op/cycle while out_ready=1.
- Bubbles: if in_valid=0 while en=1, an invalid slot enters the pipe. Bubbles are not collapsed.
- Stall: when out_valid=1 and out_ready=0:
  - sum, carry_out and overflow hold stable;
  - in_ready=0;
  - every stage holds, so no data is lost or duplicated.
- Output data when out_valid=0: sum, carry_out and overflow hold their last value. Only valid-qualified values are defined.
- Simultaneous accept and release: with out_valid=1, out_ready=1 and in_valid=1, the output retires and a new op enters stage 0 on the same edge.
- Ordering: results always leave in acceptance order.
- Arithmetic: sum = (a + b_eff + c0) mod 2^WIDTH, bit-exact versus a single full-width ripple adder for every WIDTH and SEG. WIDTH=SEG is legal: one stage, latency 1.

Test Plan:
- Default params, a=0xFFFF, b=0x0001, carry_in=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, carry_out=1, overflow=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1. Then a=0x8000, b=0x0001, sub=1, carry_in=1 (ignored) -> sum=0x7FFF, carry_out=1, overflow=1.
- Back-to-back 6 random ops with out_ready=1 -> 6 consecutive out_valid cycles starting 4 cycles after the first accept, in order, each matching the reference model.
- Stall: hold out_ready=0 for 3 cycles while out_valid=1 and in_valid=1 -> in_ready=0 and sum unchanged for those 3 cycles. After release, all results arrive in order with no loss or duplicates.
- Reset mid-operation: 3 ops in flight, assert rst for 1 cycle -> out_valid=0 from the next cycle and no stale result ever appears. A new op after reset completes with 4-cycle latency.
- Parameter sweep (WIDTH,SEG) = (8,8), (32,4), (12,3) with 200 random ops each, random in_valid and out_ready -> all results match the model and latency equals WIDTH/SEG when unstalled.

Source files
------------

// File: rtl/pipelined_adder_param.sv
// Pipelined add/subtract: WIDTH bits resolved SEG bits per stage with a
// registered carry between stages, one operation accepted per clock, and
// valid/ready handshakes on both sides.
module pipelined_adder_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned STAGES = WIDTH / SEG;
    localparam int unsigned LAST   = STAGES - 1;

    // Per-stage registers: valid, skewed operands, partial sum, segment carry
    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  opa_q  [STAGES];
    logic [WIDTH-1:0]  opb_q  [STAGES];
    logic [WIDTH-1:0]  part_q [STAGES];
    logic [STAGES-1:0] cry_q;
    logic              ovf_q;

    // Stage inputs and next values
    logic              en;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_a  [STAGES];
    logic [WIDTH-1:0]  src_b  [STAGES];
    logic [WIDTH-1:0]  src_p  [STAGES];
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  nxt_p  [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic              nxt_ovf;
    logic [SEG:0]      seg_sum;

    // Global enable, stage source muxing and per-segment addition
    always_comb begin
        en      = !vld_q[LAST] || out_ready;
        seg_sum = '0;

        // Stage 0 takes the operands; subtraction is a + ~b + 1
        src_v[0] = in_valid;
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_c[0] = sub | carry_in;
        src_p[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            src_v[k] = vld_q[k-1];
            src_a[k] = opa_q[k-1];
            src_b[k] = opb_q[k-1];
            src_c[k] = cry_q[k-1];
            src_p[k] = part_q[k-1];
        end

        for (int k = 0; k < int'(STAGES); k++) begin
            seg_sum = {1'b0, src_a[k][k*SEG +: SEG]}
                    + {1'b0, src_b[k][k*SEG +: SEG]}
                    + (SEG+1)'(src_c[k]);
            nxt_p[k] = src_p[k];
            nxt_p[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            nxt_c[k] = seg_sum[SEG];
        end

        // Carry into the MSB is a ^ b ^ sum at that bit
        nxt_ovf = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1]
                ^ nxt_p[LAST][WIDTH-1] ^ nxt_c[LAST];
    end

    // Pipeline advance; data registers only load on valid slots so outputs hold across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cry_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < int'(STAGES); k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                part_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= src_v;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (src_v[k]) begin
                    opa_q[k]  <= src_a[k];
                    opb_q[k]  <= src_b[k];
                    part_q[k] <= nxt_p[k];
                    cry_q[k]  <= nxt_c[k];
                end
            end
            if (src_v[LAST]) begin
                ovf_q <= nxt_ovf;
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[LAST];
    assign sum       = part_q[LAST];
    assign carry_out = cry_q[LAST];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_param.sv
// Bench for pipelined_adder_param: directed table and corner sequences on the
// default configuration, plus random sweeps on three other configurations.
module tb_pipelined_adder_param;

    localparam int unsigned ST = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, carry_in, sub;
    logic        out_valid, out_ready, carry_out, overflow;
    logic [15:0] a, b, sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_param #(.WIDTH(16), .SEG(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        int          acc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[9];

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        exp_t        r;
        logic [15:0] be;
        logic [16:0] f;
        be = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, be} + 17'(s ? 1'b1 : c);
        r.s  = f[15:0];
        r.co = f[16];
        r.ov = (x[15] == be[15]) && (f[15] != x[15]);
        r.acc = 0;
        r.chk_lat = 1'b0;
        return r;
    endfunction

    // Apply inputs for this cycle and record the op if it will be accepted
    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s, input logic ordy, input bit chk);
        exp_t e;
        in_valid = v; a = x; b = y; carry_in = c; sub = s; out_ready = ordy;
        #1;
        if (!rst && v && in_ready) begin
            e = model(x, y, c, s);
            e.acc = cyc;
            e.chk_lat = chk;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
            idle();
        end
        check("drain_empty", 64'(sb_q.size()), 64'(0));
    endtask

    // Scoreboard monitor for the default-configuration DUT
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #3;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got sum %0h, want no result", sum);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_sum", 64'(sum), 64'(e.s));
                    check("sb_carry", 64'(carry_out), 64'(e.co));
                    check("sb_ovf", 64'(overflow), 64'(e.ov));
                    if (e.chk_lat) check("sb_latency", 64'(cyc - e.acc), 64'(ST));
                end
            end
        end
    end

    // Directed sequence on the default configuration
    initial begin : main
        logic [15:0] held;
        bit          got;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_carry", 64'(carry_out), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        // Isolated ops from the table, each checked for value and exact latency
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb, 1'b1, 1'b1);
            got = 1'b0;
            for (int k = 1; k <= 10 && !got; k++) begin
                @(posedge clk); #1;
                idle();
                if (out_valid) begin
                    got = 1'b1;
                    check($sformatf("tbl%0d_latency", i), 64'(k), 64'(ST));
                    check($sformatf("tbl%0d_sum", i), 64'(sum), 64'(tbl[i].s));
                    check($sformatf("tbl%0d_carry", i), 64'(carry_out), 64'(tbl[i].co));
                    check($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].ov));
                end
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL tbl%0d_timeout: got no result, want one within 10 cycles", i);
            end
        end
        drain(10);

        // Back-to-back random ops at full rate
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
        end
        drain(20);

        // Output stall with new operands waiting
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        check("stall_reached", 64'(got), 64'(1));
        held = sum;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) begin
                @(posedge clk); #1;
            end
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
            check($sformatf("stall%0d_in_ready", j), 64'(in_ready), 64'(0));
            check($sformatf("stall%0d_sum_hold", j), 64'(sum), 64'(held));
            check($sformatf("stall%0d_out_valid", j), 64'(out_valid), 64'(1));
        end
        drain(30);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        idle();
        check("rst_mid_in_ready", 64'(in_ready), 64'(1));
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            check($sformatf("rst_mid_quiet%0d", i), 64'(out_valid), 64'(0));
        end
        @(posedge clk); #1;
        drive(1'b1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, 1'b1);
        drain(10);

        for (int i = 0; i < 20000 && n_done < 3; i++) @(posedge clk);
        if (n_done < 3) begin
            total++;
            bad++;
            $display("FAIL sweep_timeout: got %0d sweeps done, want 3", n_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Random sweeps on other (WIDTH, SEG) configurations with random handshakes
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int unsigned SW = (g == 0) ? 8 : ((g == 1) ? 32 : 12);
        localparam int unsigned SS = (g == 0) ? 8 : ((g == 1) ? 4 : 3);
        localparam int unsigned SN = SW / SS;

        logic          s_rst, s_iv, s_ir, s_ci, s_sub, s_ov_v, s_or, s_co, s_of;
        logic [SW-1:0] s_a, s_b, s_sum;

        typedef struct {
            logic [SW-1:0] s;
            logic          co;
            logic          ov;
            int            acc;
            int            stl;
        } se_t;

        se_t q[$];
        int  sent;
        int  stalls;

        pipelined_adder_param #(.WIDTH(SW), .SEG(SS)) u_dut (
            .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
            .a(s_a), .b(s_b), .carry_in(s_ci), .sub(s_sub),
            .out_valid(s_ov_v), .out_ready(s_or),
            .sum(s_sum), .carry_out(s_co), .overflow(s_of)
        );

        initial begin : run
            se_t           e;
            logic [SW-1:0] be;
            logic [SW:0]   f;
            s_rst = 1'b1; s_iv = 1'b0; s_a = '0; s_b = '0; s_ci = 1'b0; s_sub = 1'b0; s_or = 1'b1;
            sent = 0;
            stalls = 0;
            repeat (2) @(posedge clk);
            #1;
            s_rst = 1'b0;
            for (int cy = 0; cy < 5000 && (sent < 200 || q.size() != 0); cy++) begin
                @(posedge clk); #1;
                s_iv  = (sent < 200) && ($urandom_range(0, 3) != 0);
                s_a   = SW'($urandom);
                s_b   = SW'($urandom);
                s_ci  = 1'($urandom);
                s_sub = 1'($urandom);
                s_or  = ($urandom_range(0, 3) != 0);
                #1;
                if (s_ov_v && s_or) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sweep%0d_unexpected: got result %0h, want none", g, s_sum);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("sweep%0d_sum", g), 64'(s_sum), 64'(e.s));
                        check($sformatf("sweep%0d_carry", g), 64'(s_co), 64'(e.co));
                        check($sformatf("sweep%0d_ovf", g), 64'(s_of), 64'(e.ov));
                        check($sformatf("sweep%0d_latency", g), 64'(cy - e.acc),
                              64'(int'(SN) + stalls - e.stl));
                    end
                end
                if (s_iv && s_ir) begin
                    be = s_sub ? ~s_b : s_b;
                    f  = {1'b0, s_a} + {1'b0, be} + (SW+1)'(s_sub | s_ci);
                    e.s   = f[SW-1:0];
                    e.co  = f[SW];
                    e.ov  = (s_a[SW-1] == be[SW-1]) && (f[SW-1] != s_a[SW-1]);
                    e.acc = cy;
                    e.stl = stalls;
                    q.push_back(e);
                    sent++;
                end
                if (!s_ir) stalls++;
            end
            if (sent < 200 || q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL sweep%0d_timeout: got sent=%0d pending=%0d, want sent=200 pending=0",
                         g, sent, q.size());
            end
            n_done++;
        end
    end

endmodule
